unified_buffer: RTL and testbench
=================================

# unified_buffer

- On-chip row-organised SRAM buffer feeding the systolic array.
- Stores rows of `SYSTOLIC_ARRAY_WIDTH` lanes × `DATA_WIDTH` bits.
- Has one row-wide write port and three independent row-wide read ports (A, B, C) with 1-cycle registered read latency.
- Sits between the host/DMA load path and the array's operand/accumulator feeders.

## Interface
Parameters:
- `DATA_WIDTH`, 32, bits per lane.
- `SYSTOLIC_ARRAY_WIDTH`, 16, lanes per row.
- `ADDR_WIDTH`, 10, row address bits; depth = 2^`ADDR_WIDTH` rows (1024).

Ports (`W` = `DATA_WIDTH`, `N` = `SYSTOLIC_ARRAY_WIDTH`):
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `wr_addr`  in  `ADDR_WIDTH`  write row address.
- `wr_en`  in  1  write enable.
- `wr_data`  in  `W` × [`N`] unpacked  row to write; lane i = `wr_data[i]`.
- `rd_addr_a` / `rd_addr_b` / `rd_addr_c`  in  `ADDR_WIDTH`  read row address, per port.
- `rd_en_a` / `rd_en_b` / `rd_en_c`  in  1  read enable, per port.
- `rd_data_a` / `rd_data_b` / `rd_data_c`  out  `W` × [`N`] unpacked  registered read row, per port.

## Operation
- Storage: 2^`ADDR_WIDTH` rows × `N` lanes × `W` bits.
- Storage is not cleared by `rst`; contents are undefined until written.
- Write: at a rising edge with `wr_en`=1, all `N` lanes of `wr_data` are written to row `wr_addr`.
- Writes are whole-row only; there are no lane or byte enables.
- Read: at a rising edge with `rd_en_x`=1, row `rd_addr_x` is captured into the `rd_data_x` register.
- Ports A, B and C are fully independent. They may read the same or different rows in the same cycle with no conflict or stall.
- When `rd_en_x`=0, `rd_data_x` holds its last value.
- Reset: while `rst`=1 at an edge, all `rd_data_a/b/c` lanes are cleared to 0. Writes and reads are suppressed that cycle.
- Read-during-write to the same row in the same cycle is read-first by default: the port returns the old row contents. See Configuration for the alternative.
- Writes to one row never disturb any other row.
- The full address range is valid; there is no out-of-range case and no wrap logic.

## Timing
- Read latency is 1 cycle. Address and enable are sampled at edge T; data is valid after edge T and stays stable until the next enabled read or reset.
- Write latency is 1 cycle. A row written at edge T is readable by a read sampled at edge T+1 or later.
- There is no handshake, no backpressure and no busy state. The block accepts one write and three reads every cycle.
- Reset values: `rd_data_a/b/c` = all zeros on every lane.
- There is no state machine.

## Configuration
- Macro: `UB_WRITE_BYPASS_EN`.
- Undefined (default): read-first. A read of row R in the same cycle as a write to row R returns the previous contents of R.
- Defined: write-first bypass. Any read port whose `rd_addr_x` equals `wr_addr`, with `wr_en`=1 and `rd_en_x`=1 in the same cycle, captures `wr_data` instead of the stored row.
- In both modes the stored row is updated identically.

## Test plan
- **Basic write/read:** write row 10 with lane i = 1000+i; next cycle read port A at 10 for one cycle -> 1 cycle later `rd_data_a[i]` = 1000+i for all 16 lanes.
- **Triple-port read:** write row 55 with lane i = 5500+i; read A, B and C at 55 in the same cycle -> all three ports output 5500+i on every lane.
- **Address independence:** after the first scenario, write row 100 with lane i = 9999+i; read A at 10 -> still 1000+i, not 9999+i.
- **Hold and independence:** read A at 10 and B at 100 simultaneously -> A = 1000+i, B = 9999+i. Then deassert all `rd_en` and change the addresses for 3 cycles -> outputs unchanged.
- **Reset:** assert `rst` for one edge after the reads above -> all `rd_data_a/b/c` lanes read 0. Then read row 55 with no rewrite -> 5500+i, since storage is preserved across reset.
- **Same-cycle read/write on row 10:** write lane i = 7000+i while port C reads row 10 in the same cycle.
  - Macro off: port C returns 1000+i.
  - Macro on: port C returns 7000+i.
  - A subsequent read returns 7000+i in both modes.

Source files
------------

// File: rtl/unified_buffer.sv
// unified_buffer: row-organised on-chip buffer feeding the systolic array.
// One row-wide write port, three independent row-wide read ports (A/B/C),
// each with a 1-cycle registered read.
// Optional feature macro: UB_WRITE_BYPASS_EN. When it is defined, a read of
// the row being written in the same cycle returns the new data (write-first).
// When it is undefined, that read returns the old row contents (read-first).
module unified_buffer #(
    parameter int unsigned DATA_WIDTH           = 32,
    parameter int unsigned SYSTOLIC_ARRAY_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH           = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic                    wr_en,
    input  logic [DATA_WIDTH-1:0]   wr_data   [SYSTOLIC_ARRAY_WIDTH],
    input  logic [ADDR_WIDTH-1:0]   rd_addr_a,
    input  logic [ADDR_WIDTH-1:0]   rd_addr_b,
    input  logic [ADDR_WIDTH-1:0]   rd_addr_c,
    input  logic                    rd_en_a,
    input  logic                    rd_en_b,
    input  logic                    rd_en_c,
    output logic [DATA_WIDTH-1:0]   rd_data_a [SYSTOLIC_ARRAY_WIDTH],
    output logic [DATA_WIDTH-1:0]   rd_data_b [SYSTOLIC_ARRAY_WIDTH],
    output logic [DATA_WIDTH-1:0]   rd_data_c [SYSTOLIC_ARRAY_WIDTH]
);

    localparam int unsigned W      = DATA_WIDTH;
    localparam int unsigned N      = SYSTOLIC_ARRAY_WIDTH;
    localparam int unsigned ROW_W  = W * N;
    localparam int unsigned DEPTH  = 2 ** ADDR_WIDTH;
    localparam int unsigned NPORTS = 3;

    // Row storage; not reset, contents undefined until written.
    logic [ROW_W-1:0]      mem_q [DEPTH];

    logic [ROW_W-1:0]      wr_row;
    logic [ADDR_WIDTH-1:0] rd_addr [NPORTS];
    logic                  rd_en   [NPORTS];
    logic [ROW_W-1:0]      rd_row  [NPORTS];
    logic [ROW_W-1:0]      rd_d    [NPORTS];
    logic [ROW_W-1:0]      rd_q    [NPORTS];

    // Flatten the incoming lane array into one packed row word.
    always_comb begin
        wr_row = '0;
        for (int i = 0; i < int'(N); i++) begin
            wr_row[i*W +: W] = wr_data[i];
        end
    end

    // Gather the three read ports into indexable arrays.
    always_comb begin
        rd_addr[0] = rd_addr_a;
        rd_addr[1] = rd_addr_b;
        rd_addr[2] = rd_addr_c;
        rd_en[0]   = rd_en_a;
        rd_en[1]   = rd_en_b;
        rd_en[2]   = rd_en_c;
    end

    // Select the row each port would capture this cycle.
    always_comb begin
        for (int p = 0; p < int'(NPORTS); p++) begin
`ifdef UB_WRITE_BYPASS_EN
            if (wr_en && (rd_addr[p] == wr_addr)) begin
                rd_row[p] = wr_row;
            end else begin
                rd_row[p] = mem_q[rd_addr[p]];
            end
`else
            rd_row[p] = mem_q[rd_addr[p]];
`endif
        end
    end

    // Next read-register value: clear on reset, load on enable, else hold.
    always_comb begin
        for (int p = 0; p < int'(NPORTS); p++) begin
            rd_d[p] = rd_q[p];
            if (rst) begin
                rd_d[p] = '0;
            end else if (rd_en[p]) begin
                rd_d[p] = rd_row[p];
            end
        end
    end

    // Read data registers.
    always_ff @(posedge clk) begin
        for (int p = 0; p < int'(NPORTS); p++) begin
            rd_q[p] <= rd_d[p];
        end
    end

    // Whole-row write; suppressed while reset is asserted.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem_q[wr_addr] <= wr_row;
        end
    end

    // Unpack the registered rows onto the lane-array outputs.
    for (genvar i = 0; i < int'(N); i++) begin : g_lane
        assign rd_data_a[i] = rd_q[0][i*W +: W];
        assign rd_data_b[i] = rd_q[1][i*W +: W];
        assign rd_data_c[i] = rd_q[2][i*W +: W];
    end

endmodule

// File: tb/tb_unified_buffer.sv
// Directed scoreboard bench for unified_buffer (default and UB_WRITE_BYPASS_EN builds).
module tb_unified_buffer;

    localparam int unsigned W  = 32;
    localparam int unsigned N  = 16;
    localparam int unsigned AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] wr_addr;
    logic          wr_en;
    logic [W-1:0]  wr_data   [N];
    logic [AW-1:0] rd_addr_a, rd_addr_b, rd_addr_c;
    logic          rd_en_a, rd_en_b, rd_en_c;
    logic [W-1:0]  rd_data_a [N];
    logic [W-1:0]  rd_data_b [N];
    logic [W-1:0]  rd_data_c [N];

    always #5 clk = ~clk;

    unified_buffer #(
        .DATA_WIDTH(W), .SYSTOLIC_ARRAY_WIDTH(N), .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .rst(rst),
        .wr_addr(wr_addr), .wr_en(wr_en), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_addr_c(rd_addr_c),
        .rd_en_a(rd_en_a), .rd_en_b(rd_en_b), .rd_en_c(rd_en_c),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .rd_data_c(rd_data_c)
    );

    // A row is described by its base: lane i = base + i; base < 0 means all zeros.
    typedef struct {
        int    port;
        int    base;
        string tag;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   mmem[int];
    int   port_base[3];

    function automatic logic [W*N-1:0] row_of(input int base);
        logic [W*N-1:0] r;
        r = '0;
        for (int i = 0; i < int'(N); i++) begin
            r[i*W +: W] = (base < 0) ? W'(0) : W'(base + i);
        end
        return r;
    endfunction

    function automatic logic [W*N-1:0] obs_of(input int port);
        logic [W*N-1:0] r;
        r = '0;
        for (int i = 0; i < int'(N); i++) begin
            case (port)
                0:       r[i*W +: W] = rd_data_a[i];
                1:       r[i*W +: W] = rd_data_b[i];
                default: r[i*W +: W] = rd_data_c[i];
            endcase
        end
        return r;
    endfunction

    // Drive one cycle, predict all three ports, then compare after the edge.
    task automatic step(input string tag, input bit r,
                        input bit we, input int wa, input int wb,
                        input bit ea, input int aa,
                        input bit eb, input int ab,
                        input bit ec, input int ac);
        bit             en[3];
        int             ad[3];
        exp_t           e;
        logic [W*N-1:0] obs;
        logic [W*N-1:0] exp_row;
        en = '{ea, eb, ec};
        ad = '{aa, ab, ac};
        rst       = r;
        wr_en     = we;
        wr_addr   = AW'(wa);
        for (int i = 0; i < int'(N); i++) wr_data[i] = W'(wb + i);
        rd_en_a   = ea; rd_addr_a = AW'(aa);
        rd_en_b   = eb; rd_addr_b = AW'(ab);
        rd_en_c   = ec; rd_addr_c = AW'(ac);
        for (int p = 0; p < 3; p++) begin
            if (r) begin
                port_base[p] = -1;
            end else if (en[p]) begin
`ifdef UB_WRITE_BYPASS_EN
                if (we && (ad[p] == wa)) port_base[p] = wb;
                else
`endif
                port_base[p] = mmem[ad[p]];
            end
            sb.push_back('{p, port_base[p], tag});
        end
        if (we && !r) mmem[wa] = wb;
        @(posedge clk);
        @(negedge clk);
        while (sb.size() > 0) begin
            e       = sb.pop_front();
            obs     = obs_of(e.port);
            exp_row = row_of(e.base);
            n_cmp++;
            assert (obs === exp_row) else begin
                n_fail++;
                $error("FAIL %s port%0d observed=%h expected=%h", e.tag, e.port, obs, exp_row);
            end
        end
    endtask

    initial begin
        port_base = '{-1, -1, -1};
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0;
        for (int i = 0; i < int'(N); i++) wr_data[i] = '0;
        rd_en_a = 1'b0; rd_en_b = 1'b0; rd_en_c = 1'b0;
        rd_addr_a = '0; rd_addr_b = '0; rd_addr_c = '0;
        @(negedge clk);

        //    tag            rst we  wa    wb     ea aa    eb ab    ec ac
        step("reset",        1, 0,   0,    0,     1, 0,    1, 0,    1, 0);
        step("wr10",         0, 1,   10,   1000,  0, 0,    0, 0,    0, 0);
        step("rdA10",        0, 0,   0,    0,     1, 10,   0, 0,    0, 0);
        step("wr55",         0, 1,   55,   5500,  0, 0,    0, 0,    0, 0);
        step("rdABC55",      0, 0,   0,    0,     1, 55,   1, 55,   1, 55);
        step("wr100",        0, 1,   100,  9999,  0, 0,    0, 0,    0, 0);
        step("rdA10_indep",  0, 0,   0,    0,     1, 10,   0, 0,    0, 0);
        step("rdA10_B100",   0, 0,   0,    0,     1, 10,   1, 100,  0, 0);
        step("hold1",        0, 0,   0,    0,     0, 55,   0, 10,   0, 100);
        step("hold2",        0, 0,   0,    0,     0, 100,  0, 55,   0, 10);
        step("hold3",        0, 0,   0,    0,     0, 1,    0, 2,    0, 3);
        step("reset_wr_sup", 1, 1,   55,   1234,  1, 55,   1, 55,   1, 55);
        step("rd55_post_rst",0, 0,   0,    0,     1, 55,   1, 55,   1, 55);
        step("wr_edges",     0, 1,   1023, 40000, 0, 0,    0, 0,    0, 0);
        step("wr_row0",      0, 1,   0,    50000, 1, 1023, 0, 0,    0, 0);
        step("rd_edges",     0, 0,   0,    0,     1, 0,    1, 1023, 1, 100);
        step("rw_same10",    0, 1,   10,   7000,  0, 0,    0, 0,    1, 10);
        step("rd10_after",   0, 0,   0,    0,     1, 10,   1, 10,   0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
